// File: rtl/jt7759_adpcm_pkg.sv
// Shared JT7759 ADPCM constants: step-size magnitudes, state-adjust table and step lookup.
package jt7759_adpcm_pkg;

    typedef logic signed [9:0] step_t;

    // Magnitudes for nibbles 0..7; nibbles 8..15 use the same magnitude, negated.
    localparam logic [7:0] StepMag [16][8] = '{
        '{0,  0,  1,  2,  3,   5,   7,  10},
        '{0,  1,  2,  3,  4,   6,   8,  13},
        '{0,  1,  2,  4,  5,   7,  10,  15},
        '{0,  1,  3,  4,  6,   9,  13,  19},
        '{0,  2,  3,  5,  8,  11,  15,  23},
        '{0,  2,  4,  7, 10,  14,  19,  29},
        '{0,  3,  5,  8, 12,  16,  22,  33},
        '{0,  4,  7, 10, 15,  20,  29,  43},
        '{0,  4,  8, 13, 18,  25,  35,  53},
        '{0,  6, 10, 16, 22,  31,  43,  64},
        '{0,  7, 12, 19, 27,  37,  51,  76},
        '{0,  9, 16, 24, 34,  46,  64,  96},
        '{0, 11, 19, 29, 41,  57,  79, 117},
        '{0, 13, 24, 36, 50,  69,  96, 143},
        '{0, 16, 29, 44, 62,  85, 118, 175},
        '{0, 20, 36, 54, 76, 104, 144, 214}
    };

    // Two's-complement 3-bit: -1,-1,0,0,1,2,2,3
    localparam logic [2:0] AdjTbl [8] = '{
        3'b111, 3'b111, 3'b000, 3'b000, 3'b001, 3'b010, 3'b010, 3'b011
    };

    function automatic step_t step_lookup(input logic [3:0] st, input logic [3:0] n);
        logic [9:0] mag;
        mag = {2'b00, StepMag[st][n[2:0]]};
        step_lookup = n[3] ? $signed(10'd0 - mag) : $signed(mag);
    endfunction

endpackage

// File: rtl/jt7759_steptbl.sv
// Synchronous 256x10 step ROM addressed by {state, nibble}; one-cycle read latency.
module jt7759_steptbl
    import jt7759_adpcm_pkg::*;
(
    input  logic       clk,
    input  logic       en_i,
    input  logic [3:0] state_i,
    input  logic [3:0] nib_i,
    output step_t      step_o
);

    step_t step_q;

    // No reset so the read register can sit inside a block RAM.
    always_ff @(posedge clk) begin
        if (en_i) begin
            step_q <= step_lookup(state_i, nib_i);
        end
    end

    assign step_o = step_q;

endmodule

// File: rtl/jt7759_adpcm.sv
// uPD7759 ADPCM nibble decoder: S0 reads the step ROM, S1 accumulates and adapts the state.
module jt7759_adpcm
    import jt7759_adpcm_pkg::*;
(
    input  logic       rst,
    input  logic       clk,
    input  logic       cen_dec,
    input  logic       dec_rst,
    input  logic [3:0] dec_din,
    output logic [7:0] sound,
    output logic       snd_ok
);

    logic [3:0] state_q, state_d;
    logic [7:0] sound_q, sound_d;
    logic [2:0] adj_q, adj_d;
    logic       v1_q, v1_d;
    logic       snd_ok_q, snd_ok_d;
    logic       s0_go;
    step_t      step;

    logic signed [10:0] sum;
    logic signed [5:0]  st_sum;

    assign s0_go = cen_dec & ~dec_rst;

    jt7759_steptbl u_steptbl (
        .clk     (clk),
        .en_i    (s0_go),
        .state_i (state_q),
        .nib_i   (dec_din),
        .step_o  (step)
    );

    always_comb begin
        sum     = $signed({{3{sound_q[7]}}, sound_q}) + $signed({step[9], step});
        // 6 bits so that 15 + 3 does not wrap before the clamp
        st_sum  = $signed({2'b00, state_q}) + $signed({{3{adj_q[2]}}, adj_q});
        sound_d  = sound_q;
        state_d  = state_q;
        adj_d    = adj_q;
        v1_d     = s0_go;
        snd_ok_d = 1'b0;

        if (s0_go) begin
            adj_d = AdjTbl[dec_din[2:0]];
        end

        if (dec_rst) begin
            sound_d  = 8'd0;
            state_d  = 4'd0;
            v1_d     = 1'b0;
            snd_ok_d = |sound_q;
        end else if (v1_q) begin
            if (sum > 11'sd127) begin
                sound_d = 8'h7f;
            end else if (sum < -11'sd128) begin
                sound_d = 8'h80;
            end else begin
                sound_d = sum[7:0];
            end

            if (st_sum < 6'sd0) begin
                state_d = 4'd0;
            end else if (st_sum > 6'sd15) begin
                state_d = 4'd15;
            end else begin
                state_d = st_sum[3:0];
            end
            snd_ok_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sound_q  <= 8'd0;
            state_q  <= 4'd0;
            adj_q    <= 3'd0;
            v1_q     <= 1'b0;
            snd_ok_q <= 1'b0;
        end else begin
            sound_q  <= sound_d;
            state_q  <= state_d;
            adj_q    <= adj_d;
            v1_q     <= v1_d;
            snd_ok_q <= snd_ok_d;
        end
    end

    assign sound  = sound_q;
    assign snd_ok = snd_ok_q;

endmodule

// File: tb/tb_jt7759_adpcm.sv
// Scoreboard bench for jt7759_adpcm against an arithmetic uPD7759 reference model.
module tb_jt7759_adpcm;

    logic       rst, clk, cen_dec, dec_rst;
    logic [3:0] dec_din;
    logic [7:0] sound;
    logic       snd_ok;

    jt7759_adpcm dut (
        .rst     (rst),
        .clk     (clk),
        .cen_dec (cen_dec),
        .dec_rst (dec_rst),
        .dec_din (dec_din),
        .sound   (sound),
        .snd_ok  (snd_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_cen = -100;

    typedef struct {
        int snd;
        int cyc;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    // Reference model
    int mag_tbl[16][8] = '{
        '{0,  0,  1,  2,  3,   5,   7,  10}, '{0,  1,  2,  3,  4,   6,   8,  13},
        '{0,  1,  2,  4,  5,   7,  10,  15}, '{0,  1,  3,  4,  6,   9,  13,  19},
        '{0,  2,  3,  5,  8,  11,  15,  23}, '{0,  2,  4,  7, 10,  14,  19,  29},
        '{0,  3,  5,  8, 12,  16,  22,  33}, '{0,  4,  7, 10, 15,  20,  29,  43},
        '{0,  4,  8, 13, 18,  25,  35,  53}, '{0,  6, 10, 16, 22,  31,  43,  64},
        '{0,  7, 12, 19, 27,  37,  51,  76}, '{0,  9, 16, 24, 34,  46,  64,  96},
        '{0, 11, 19, 29, 41,  57,  79, 117}, '{0, 13, 24, 36, 50,  69,  96, 143},
        '{0, 16, 29, 44, 62,  85, 118, 175}, '{0, 20, 36, 54, 76, 104, 144, 214}
    };
    int adj_tbl[8] = '{-1, -1, 0, 0, 1, 2, 2, 3};
    int m_sound = 0;
    int m_state = 0;

    function automatic void model_nib(input int n);
        int step, s, st;
        step = (n >= 8) ? -mag_tbl[m_state][n - 8] : mag_tbl[m_state][n];
        s = m_sound + step;
        m_sound = (s > 127) ? 127 : ((s < -128) ? -128 : s);
        st = m_state + adj_tbl[n % 8];
        m_state = (st < 0) ? 0 : ((st > 15) ? 15 : st);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs must respect the minimum cen_dec spacing
    always @(posedge clk) begin
        if (rst) begin
            last_cen <= -100;
        end else if (cen_dec && !dec_rst) begin
            if (cyc - last_cen < 3) begin
                failures++;
                $display("FAIL cen_spacing: got %0d cycles expected >= 3", cyc - last_cen);
            end
            last_cen <= cyc;
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (!rst && snd_ok) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_snd_ok: got sound %0d expected no strobe (cycle %0d)",
                         $signed(sound), cyc);
            end else begin
                mon_e = q.pop_front();
                check("sound", int'($signed(sound)), mon_e.snd);
                check("snd_ok_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_nib(input int n, input int gap);
        exp_t e;
        cen_dec = 1'b1;
        dec_din = 4'(n);
        model_nib(n);
        e.snd = m_sound;
        e.cyc = cyc + 2;
        q.push_back(e);
        tick();
        cen_dec = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic rst_op(input int hold, input bit with_cen);
        exp_t e;
        dec_rst = 1'b1;
        cen_dec = with_cen;
        dec_din = 4'($urandom_range(0, 15));
        if (m_sound != 0) begin
            e.snd = 0;
            e.cyc = cyc + 1;
            q.push_back(e);
        end
        m_sound = 0;
        m_state = 0;
        tick();
        cen_dec = 1'b0;
        repeat (hold - 1) tick();
        dec_rst = 1'b0;
        tick();
    endtask

    // dec_rst lands on the S1 edge of this nibble, which must be discarded
    task automatic nib_then_rst(input int n, input int hold);
        cen_dec = 1'b1;
        dec_din = 4'(n);
        tick();
        cen_dec = 1'b0;
        rst_op(hold, 1'b0);
    endtask

    task automatic async_rst();
        cen_dec = 1'b1;
        dec_din = 4'd7;
        tick();
        cen_dec = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_sound", int'($signed(sound)), 0);
        check("async_snd_ok", int'(snd_ok), 0);
        m_sound = 0;
        m_state = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        rst     = 1'b1;
        cen_dec = 1'b0;
        dec_rst = 1'b0;
        dec_din = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_sound", int'(sound), 0);
        check("reset_snd_ok", int'(snd_ok), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        send_nib(7, 3);
        check("first_7", int'($signed(sound)), 10);
        send_nib(7, 5);
        check("second_7", int'($signed(sound)), 29);

        rst_op(2, 1'b0);
        for (int i = 0; i < 20; i++) send_nib(0, 3);
        check("zeros_hold", int'($signed(sound)), 0);

        rst_op(1, 1'b1);
        for (int i = 0; i < 40; i++) send_nib(7, 3);
        check("sat_high", int'($signed(sound)), 127);

        rst_op(1, 1'b0);
        for (int i = 0; i < 40; i++) send_nib(15, 4);
        check("sat_low", int'($signed(sound)), -128);

        rst_op(1, 1'b0);
        send_nib(7, 3);
        send_nib(7, 3);
        nib_then_rst(7, 1);
        check("rst_on_s1", int'($signed(sound)), 0);
        send_nib(7, 4);
        check("after_rst_7", int'($signed(sound)), 10);

        for (int i = 0; i < 300; i++) begin
            int r;
            int n;
            r = $urandom_range(0, 9);
            n = $urandom_range(0, 15);
            if (i == 150) async_rst();
            if (r == 0) rst_op($urandom_range(1, 4), 1'($urandom_range(0, 1)));
            else if (r == 1) nib_then_rst(n, $urandom_range(1, 3));
            else send_nib(n, $urandom_range(3, 64));
        end

        repeat (8) tick();
        check("drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
